// File: rtl/axis_downsizer_pkg.sv
// Shared types and helpers for the AXI4-Stream width reducer.
// Segment-liveness helpers act on a fixed-width mask so they stay plain functions.
package axis_downsizer_pkg;

  localparam int MaxSegs = 64;

  typedef logic [MaxSegs-1:0] seg_mask_t;

  typedef enum logic [0:0] {
    StEmpty,
    StSend
  } state_e;

  function automatic int calc_seg_count(input int s_keep_width, input int m_keep_width);
    return (m_keep_width > 0) ? s_keep_width / m_keep_width : 0;
  endfunction

  function automatic int calc_ptr_width(input int seg_count);
    return (seg_count > 1) ? $clog2(seg_count) : 1;
  endfunction

  // Lowest live segment at or above 'from'; 0 when none is live.
  function automatic int first_live(input seg_mask_t live, input int from);
    int idx;
    bit found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < MaxSegs; i++) begin
      if (!found && i >= from && live[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Highest live segment; 0 when none is live, so an empty last beat ends on segment 0.
  function automatic int last_live(input seg_mask_t live);
    int idx;
    idx = 0;
    for (int i = 0; i < MaxSegs; i++) begin
      if (live[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_downsizer.sv
// AXI4-Stream width reducer: holds one wide beat and emits its live segments
// lowest first, reloading on the final segment's handshake without a bubble.
module axis_downsizer
  import axis_downsizer_pkg::*;
#(
  parameter int S_DATA_WIDTH  = 64,
  parameter int S_KEEP_WIDTH  = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH  = 8,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = M_DATA_WIDTH / 8,
  parameter bit ID_ENABLE     = 1'b0,
  parameter int ID_WIDTH      = 8,
  parameter bit DEST_ENABLE   = 1'b0,
  parameter int DEST_WIDTH    = 8,
  parameter bit USER_ENABLE   = 1'b1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    busy
);

  localparam int MKeepInt = M_KEEP_ENABLE ? M_KEEP_WIDTH : 1;
  localparam int SegCount = calc_seg_count(S_KEEP_WIDTH, MKeepInt);
  localparam int PtrWidth = calc_ptr_width(SegCount);

  if (SegCount < 2 || (S_KEEP_WIDTH % MKeepInt) != 0 || SegCount > MaxSegs) begin : g_bad_ratio
    $error("axis_downsizer: segment count must be an exact divisor >= 2");
  end
  if ((S_DATA_WIDTH / S_KEEP_WIDTH) != (M_DATA_WIDTH / MKeepInt)) begin : g_bad_word
    $error("axis_downsizer: input and output word sizes differ");
  end

  typedef logic [PtrWidth-1:0] ptr_t;

  state_e                  state_q;
  ptr_t                    seg_ptr_q;
  logic [S_DATA_WIDTH-1:0] data_q;
  logic [S_KEEP_WIDTH-1:0] keep_q;
  logic                    last_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [USER_WIDTH-1:0]   user_q;

  seg_mask_t live_in;
  seg_mask_t live_cur;
  ptr_t      first_in;
  ptr_t      next_cur;
  logic      valid;
  logic      final_seg;
  logic      s_hs;
  logic      m_hs;

  always_comb begin
    live_in  = '0;
    live_cur = '0;
    for (int i = 0; i < SegCount; i++) begin
      live_in[i]  = |s_axis_tkeep[i*MKeepInt +: MKeepInt];
      live_cur[i] = |keep_q[i*MKeepInt +: MKeepInt];
    end
  end

  assign first_in  = ptr_t'(first_live(live_in, 0));
  assign next_cur  = ptr_t'(first_live(live_cur, int'(seg_ptr_q) + 1));
  assign final_seg = (int'(seg_ptr_q) == last_live(live_cur));

  assign valid         = (state_q == StSend);
  assign s_axis_tready = !rst && (!valid || (m_axis_tready && final_seg));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = valid && m_axis_tready;

  // A beat with no live words is kept only if it carries the frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      seg_ptr_q <= '0;
    end else if (s_hs) begin
      data_q    <= s_axis_tdata;
      keep_q    <= s_axis_tkeep;
      last_q    <= s_axis_tlast;
      id_q      <= ID_ENABLE ? s_axis_tid : '0;
      dest_q    <= DEST_ENABLE ? s_axis_tdest : '0;
      user_q    <= USER_ENABLE ? s_axis_tuser : '0;
      seg_ptr_q <= first_in;
      state_q   <= (|live_in || s_axis_tlast) ? StSend : StEmpty;
    end else if (m_hs) begin
      if (final_seg) begin
        state_q <= StEmpty;
      end else begin
        seg_ptr_q <= next_cur;
      end
    end
  end

  assign m_axis_tvalid = valid && !rst;
  assign busy          = m_axis_tvalid;
  assign m_axis_tlast  = m_axis_tvalid && last_q && final_seg;
  assign m_axis_tdata  = data_q[int'(seg_ptr_q)*M_DATA_WIDTH +: M_DATA_WIDTH];
  assign m_axis_tid    = id_q;
  assign m_axis_tdest  = dest_q;
  assign m_axis_tuser  = user_q;

  if (M_KEEP_ENABLE) begin : g_keep
    assign m_axis_tkeep = keep_q[int'(seg_ptr_q)*MKeepInt +: MKeepInt];
  end else begin : g_no_keep
    assign m_axis_tkeep = '1;
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Self-checking bench for axis_downsizer (64 -> 8 bits, keep/id/dest/user propagated).
// A per-beat word list built from the keep rules is the reference for every narrow beat.
module tb_axis_downsizer;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic [7:0] id;
    logic [7:0] dest;
    logic [2:0] user;
  } nb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tid = '0;
  logic [7:0]  s_axis_tdest = '0;
  logic [2:0]  s_axis_tuser = '0;
  logic [7:0]  m_axis_tdata;
  logic [0:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [2:0]  m_axis_tuser;
  logic        busy;

  axis_downsizer #(
    .S_DATA_WIDTH (64),
    .S_KEEP_WIDTH (8),
    .M_DATA_WIDTH (8),
    .M_KEEP_ENABLE(1'b1),
    .M_KEEP_WIDTH (1),
    .ID_ENABLE    (1'b1),
    .ID_WIDTH     (8),
    .DEST_ENABLE  (1'b1),
    .DEST_WIDTH   (8),
    .USER_ENABLE  (1'b1),
    .USER_WIDTH   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tid   (s_axis_tid),
    .s_axis_tdest (s_axis_tdest),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tuser (m_axis_tuser),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  rand_ready = 1'b0;
  nb_t exp_q[$];
  int  hs_cycles[$];
  int  s_cycles[$];
  bit  srdy_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: live words in ascending order, frame end on the last one; an empty
  // last beat becomes a single keep=0 word, an empty non-last beat vanishes.
  task automatic model_push(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [7:0] id, input logic [7:0] dest, input logic [2:0] u);
    nb_t beats[$];
    nb_t b;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        b.data = d[i*8 +: 8];
        b.keep = 1'b1;
        b.last = 1'b0;
        b.id   = id;
        b.dest = dest;
        b.user = u;
        beats.push_back(b);
      end
    end
    if (beats.size() == 0 && l) begin
      b.data = d[7:0];
      b.keep = 1'b0;
      b.last = 1'b1;
      b.id   = id;
      b.dest = dest;
      b.user = u;
      beats.push_back(b);
    end else if (beats.size() != 0) begin
      b = beats[beats.size()-1];
      b.last = l;
      beats[beats.size()-1] = b;
    end
    foreach (beats[j]) exp_q.push_back(beats[j]);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    nb_t cur;
    nb_t held;
    nb_t e;
    bit  stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        stalled = 1'b0;
      end else begin
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};
        if (stalled) begin
          check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          check("stall_fields", 64'(cur), 64'(held));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          hs_cycles.push_back(cyc);
          srdy_q.push_back(s_axis_tready);
          check("m_beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_beat", 64'(cur), 64'(e));
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = cur;
        if (s_axis_tvalid && s_axis_tready) begin
          s_cycles.push_back(cyc);
          model_push(s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest,
                     s_axis_tuser);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic clear_logs();
    hs_cycles.delete();
    s_cycles.delete();
    srdy_q.delete();
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [7:0] id, input logic [7:0] dest, input logic [2:0] u);
    bit done;
    done          = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tid    = id;
    s_axis_tdest  = dest;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      done = s_axis_tready && !rst;
      step();
    end
    check("s_handshake", 64'(done), 64'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 5000 && (exp_q.size() != 0 || m_axis_tvalid); n++) step();
    check("drain", {62'd0, exp_q.size() != 0, m_axis_tvalid}, 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  k;
    int          nb;
    int          sel;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
    step();

    // Three full beats, sink always ready
    m_axis_tready = 1'b1;
    clear_logs();
    for (int b = 0; b < 3; b++) begin
      send_beat({$urandom, $urandom}, 8'hff, 1'(b == 2), 8'(b + 1), 8'h40, 3'(b));
    end
    idle();
    wait_drain();
    check("full_count", 64'(hs_cycles.size()), 64'd24);
    check("full_latency", 64'(hs_cycles[0] - s_cycles[0]), 64'd1);
    check("full_contiguous", 64'(hs_cycles[23] - hs_cycles[0]), 64'd23);

    // Low half, last beat: s ready coincides with the final narrow handshake
    clear_logs();
    send_beat(64'h1122334455667788, 8'h0f, 1'b1, 8'h07, 8'h08, 3'd5);
    idle();
    wait_drain();
    check("half_count", 64'(hs_cycles.size()), 64'd4);
    check("half_srdy_mid", 64'(srdy_q[2]), 64'd0);
    check("half_srdy_final", 64'(srdy_q[3]), 64'd1);

    // Sparse keep: segments 0, 2, 5, 7 back to back
    clear_logs();
    send_beat(64'h8877665544332211, 8'ha5, 1'b0, 8'h33, 8'h44, 3'd2);
    idle();
    wait_drain();
    check("sparse_count", 64'(hs_cycles.size()), 64'd4);
    check("sparse_no_bubble", 64'(hs_cycles[3] - hs_cycles[0]), 64'd3);

    // Empty last beat keeps the frame end
    clear_logs();
    send_beat(64'hdeadbeefcafef00d, 8'h00, 1'b1, 8'h51, 8'h52, 3'd3);
    idle();
    wait_drain();
    check("empty_last_count", 64'(hs_cycles.size()), 64'd1);

    // Empty non-last beat is dropped without a stall
    clear_logs();
    send_beat(64'h0102030405060708, 8'h00, 1'b0, 8'h61, 8'h62, 3'd1);
    send_beat(64'h1112131415161718, 8'hff, 1'b1, 8'h63, 8'h64, 3'd6);
    idle();
    wait_drain();
    check("drop_next_accept", 64'(s_cycles[1] - s_cycles[0]), 64'd1);
    check("drop_count", 64'(hs_cycles.size()), 64'd8);
    check("drop_no_output", 64'(hs_cycles[0] - s_cycles[1]), 64'd1);

    // Reset with segment 3 of 8 pending
    clear_logs();
    send_beat(64'h0f0e0d0c0b0a0908, 8'hff, 1'b1, 8'h71, 8'h72, 3'd4);
    idle();
    for (int n = 0; n < 50 && hs_cycles.size() < 3; n++) step();
    check("pre_rst_segments", 64'(hs_cycles.size()), 64'd3);
    m_axis_tready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
    step();
    @(negedge clk);
    check("mid_rst_tvalid_next", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_busy_next", 64'(busy), 64'd0);
    check("mid_rst_s_tready_next", 64'(s_axis_tready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_s_tready", 64'(s_axis_tready), 64'd1);
    check("rst_release_tvalid", 64'(m_axis_tvalid), 64'd0);
    step();
    m_axis_tready = 1'b1;
    clear_logs();
    send_beat(64'ha1a2a3a4a5a6a7a8, 8'hff, 1'b0, 8'h81, 8'h82, 3'd1);
    send_beat(64'hb1b2b3b4b5b6b7b8, 8'h3c, 1'b1, 8'h83, 8'h84, 3'd2);
    idle();
    wait_drain();
    check("post_rst_frame_count", 64'(hs_cycles.size()), 64'd12);

    // Random frames against a 50% ready sink
    rand_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        d   = {$urandom, $urandom};
        sel = $urandom_range(0, 9);
        if (sel == 0) k = 8'h00;
        else if (sel < 5) k = 8'hff;
        else k = 8'($urandom);
        send_beat(d, k, 1'(b == nb - 1), 8'($urandom), 8'($urandom), 3'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          idle();
          repeat ($urandom_range(1, 2)) step();
        end
      end
    end
    idle();
    rand_ready = 1'b0;
    step();
    m_axis_tready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
